// File: rtl/tone_divider.sv
// Multi-channel programmable square-wave generator: each channel divides clk by a
// run-time half-period, with glitch-free half-period updates committed at boundaries.
module tone_divider #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned W        = 20,
  parameter int unsigned DEF_HALF = 50000,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [W-1:0]     cfg_half,
  input  logic [NCH-1:0]   en,
  output logic [NCH-1:0]   wave_out,
  output logic [NCH-1:0]   edge_tick,
  output logic [NCH-1:0]   pend
);

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [W-1:0] half;
    logic [W-1:0] shadow;
    logic [W-1:0] cnt;
    logic         wave;
    logic         tick;
    logic         pend;
  } ch_t;

  localparam ch_t CH_RST = '{
    half:   W'(DEF_HALF),
    shadow: '0,
    cnt:    '0,
    wave:   1'b0,
    tick:   1'b0,
    pend:   1'b0
  };

  ch_t       ch_q       [NCH];
  ch_t       ch_d       [NCH];
  ch_state_e state_c    [NCH];
  logic      boundary_c [NCH];
  logic      wr_hit_c   [NCH];

  // Per-channel state register; every channel is fully independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) begin
        ch_q[i] <= CH_RST;
      end
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        ch_q[i] <= ch_d[i];
      end
    end
  end

  // Channel mode is decoded from the registers rather than stored separately.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      state_c[i]    = (en[i] && (ch_q[i].half != '0)) ? CH_RUN : CH_IDLE;
      boundary_c[i] = (ch_q[i].cnt == (ch_q[i].half - W'(1)));
      wr_hit_c[i]   = cfg_we && (int'(cfg_ch) == i);
    end
  end

  // Next-state: counting, toggling, commit of the shadow, then config capture.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      ch_d[i]      = ch_q[i];
      ch_d[i].tick = 1'b0;
      case (state_c[i])
        CH_IDLE: begin
          ch_d[i].cnt  = '0;
          ch_d[i].wave = 1'b0;
          if (ch_q[i].pend) begin
            ch_d[i].half = ch_q[i].shadow;
            ch_d[i].pend = 1'b0;
          end
        end
        CH_RUN: begin
          if (boundary_c[i]) begin
            ch_d[i].cnt  = '0;
            ch_d[i].wave = ~ch_q[i].wave;
            ch_d[i].tick = 1'b1;
            if (ch_q[i].pend) begin
              ch_d[i].half = ch_q[i].shadow;
              ch_d[i].pend = 1'b0;
            end
          end else begin
            ch_d[i].cnt = ch_q[i].cnt + W'(1);
          end
        end
        default: begin
          ch_d[i] = CH_RST;
        end
      endcase
      // A write landing on a commit cycle is kept for the next boundary.
      if (wr_hit_c[i]) begin
        ch_d[i].shadow = cfg_half;
        ch_d[i].pend   = 1'b1;
      end
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    wave_out  = '0;
    edge_tick = '0;
    pend      = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      wave_out[i]  = ch_q[i].wave;
      edge_tick[i] = ch_q[i].tick;
      pend[i]      = ch_q[i].pend;
    end
  end

endmodule

// File: tb/tb_tone_divider.sv
// Self-checking bench for tone_divider: vector table, directed corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_tone_divider;

  localparam int NCH = 4;
  localparam int W   = 20;
  localparam int DH  = 4;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [W-1:0]     cfg_half;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   wave_out;
  logic [NCH-1:0]   edge_tick;
  logic [NCH-1:0]   pend;

  logic             we5;
  logic [2:0]       ch5;
  logic [7:0]       half5;
  logic [4:0]       en5;
  logic [4:0]       w5;
  logic [4:0]       t5;
  logic [4:0]       p5;

  tone_divider #(.NCH(NCH), .W(W), .DEF_HALF(DH)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
    .en(en), .wave_out(wave_out), .edge_tick(edge_tick), .pend(pend)
  );

  tone_divider #(.NCH(5), .W(8), .DEF_HALF(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_we(we5), .cfg_ch(ch5), .cfg_half(half5),
    .en(en5), .wave_out(w5), .edge_tick(t5), .pend(p5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  // Reference model: each running channel remembers the edge at which its current
  // half-period started; it toggles when h edges have elapsed.
  int   m_h     [NCH];
  int   m_s     [NCH];
  int   m_start [NCH];
  logic m_pend  [NCH];
  logic m_wave  [NCH];
  logic m_tick  [NCH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_n, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_h[i] = DH; m_s[i] = 0; m_start[i] = -1;
      m_pend[i] = 1'b0; m_wave[i] = 1'b0; m_tick[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] e, input logic we, input logic [1:0] ch,
                            input logic [W-1:0] half);
    for (int i = 0; i < NCH; i++) begin
      logic commit;
      commit = 1'b0;
      m_tick[i] = 1'b0;
      if (!e[i] || m_h[i] == 0) begin
        m_wave[i] = 1'b0; m_start[i] = -1; commit = m_pend[i];
      end else begin
        if (m_start[i] < 0) m_start[i] = cyc_n;
        if (cyc_n - m_start[i] + 1 == m_h[i]) begin
          m_wave[i] = ~m_wave[i]; m_tick[i] = 1'b1;
          m_start[i] = cyc_n + 1; commit = m_pend[i];
        end
      end
      if (commit) begin m_h[i] = m_s[i]; m_pend[i] = 1'b0; end
      if (we && int'(ch) == i) begin m_s[i] = int'(half); m_pend[i] = 1'b1; end
    end
  endtask

  // One clock: drive inputs, step the model on the edge, compare just after it.
  task automatic cyc(input logic [NCH-1:0] e, input logic we, input logic [1:0] ch,
                     input logic [W-1:0] half);
    logic [NCH-1:0] ew, et, ep;
    en = e; cfg_we = we; cfg_ch = ch; cfg_half = half;
    @(posedge clk);
    cyc_n++;
    model_edge(e, we, ch, half);
    #1;
    for (int i = 0; i < NCH; i++) begin
      ew[i] = m_wave[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
    end
    chk("model_wave", 32'(wave_out), 32'(ew));
    chk("model_tick", 32'(edge_tick), 32'(et));
    chk("model_pend", 32'(pend), 32'(ep));
    cfg_we = 1'b0;
  endtask

  task automatic cyc5(input logic [4:0] e, input logic we, input logic [2:0] ch,
                      input logic [7:0] half);
    en5 = e; we5 = we; ch5 = ch; half5 = half;
    @(posedge clk);
    #1;
    we5 = 1'b0;
  endtask

  typedef struct {
    logic         we;
    logic [1:0]   ch;
    logic [W-1:0] half;
    logic [3:0]   exp_wave;
    logic [3:0]   exp_tick;
    logic [3:0]   exp_pend;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic we, input logic [W-1:0] half,
                              input logic w, input logic t, input logic p);
    vec_t v;
    v.we = we; v.ch = 2'd0; v.half = half;
    v.exp_wave = {3'b000, w}; v.exp_tick = {3'b000, t}; v.exp_pend = {3'b000, p};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    logic exp_w;
    // ch0 at DEF_HALF=4, then a write of 2 lands at cnt=1 and commits on edge 12.
    tbl[0]  = mk(0, 0, 0, 0, 0); tbl[1]  = mk(0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0); tbl[3]  = mk(0, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0); tbl[5]  = mk(0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0); tbl[7]  = mk(0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0); tbl[9]  = mk(1, 2, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 1); tbl[11] = mk(0, 0, 1, 1, 0);
    tbl[12] = mk(0, 0, 1, 0, 0); tbl[13] = mk(0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0); tbl[15] = mk(0, 0, 1, 1, 0);

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; en = '0;
    we5 = 1'b0; ch5 = '0; half5 = '0; en5 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wave", 32'(wave_out), 32'd0);
    chk("rst_tick", 32'(edge_tick), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      cyc(4'b0001, tbl[r].we, tbl[r].ch, tbl[r].half);
      chk("tbl_wave", 32'(wave_out), 32'(tbl[r].exp_wave));
      chk("tbl_tick", 32'(edge_tick), 32'(tbl[r].exp_tick));
      chk("tbl_pend", 32'(pend), 32'(tbl[r].exp_pend));
    end

    // Idle write commits after one edge; h=1 toggles every cycle.
    cyc(4'b0001, 1'b1, 2'd1, 20'd1);
    chk("idle_pend_set", 32'(pend[1]), 32'd1);
    cyc(4'b0001, 1'b0, 2'd0, 20'd0);
    chk("idle_pend_clr", 32'(pend[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(4'b0011, 1'b0, 2'd0, 20'd0);
      chk("h1_wave", 32'(wave_out[1]), 32'((k % 2) == 0));
      chk("h1_tick", 32'(edge_tick[1]), 32'd1);
    end

    // Committing h=0 silences ch0.
    cyc(4'b0011, 1'b1, 2'd0, 20'd0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cyc(4'b0011, 1'b0, 2'd0, 20'd0);
      if (pend[0] == 1'b0) found = 1'b1;
    end
    chk("silence_commit_seen", 32'(found), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0011, 1'b0, 2'd0, 20'd0);
      chk("silent_wave", 32'(wave_out[0]), 32'd0);
      chk("silent_tick", 32'(edge_tick[0]), 32'd0);
    end

    // Restore h=4, drop en mid-high, re-enable.
    cyc(4'b0011, 1'b1, 2'd0, 20'd4);
    cyc(4'b0011, 1'b0, 2'd0, 20'd0);
    chk("restore_pend", 32'(pend[0]), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(4'b0011, 1'b0, 2'd0, 20'd0);
      if (wave_out[0]) found = 1'b1;
    end
    chk("restore_rise_seen", 32'(found), 32'd1);
    cyc(4'b0011, 1'b0, 2'd0, 20'd0);
    chk("mid_high_wave", 32'(wave_out[0]), 32'd1);
    cyc(4'b0010, 1'b0, 2'd0, 20'd0);
    chk("disable_wave", 32'(wave_out[0]), 32'd0);
    chk("disable_tick", 32'(edge_tick[0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc(4'b0011, 1'b0, 2'd0, 20'd0);
      chk("reen_wave", 32'(wave_out[0]), 32'(k == 4));
      chk("reen_tick", 32'(edge_tick[0]), 32'(k == 4));
    end

    // Collisions on ch2: write 5, then 6 on the boundary edge, then 3.
    exp_w = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      logic we_k;
      logic [W-1:0] h_k;
      we_k = (k == 1) || (k == 4) || (k == 5);
      h_k  = (k == 1) ? 20'd5 : (k == 4) ? 20'd6 : 20'd3;
      cyc(4'b0111, we_k, 2'd2, we_k ? h_k : 20'd0);
      if (k == 4 || k == 9 || k == 12 || k == 15) exp_w = ~exp_w;
      chk("col_tick", 32'(edge_tick[2]), 32'(k == 4 || k == 9 || k == 12 || k == 15));
      chk("col_wave", 32'(wave_out[2]), 32'(exp_w));
      chk("col_pend", 32'(pend[2]), 32'(k <= 8));
    end

    // Randomized traffic against the model.
    begin
      logic [NCH-1:0] e_r;
      e_r = 4'b0111;
      for (int k = 0; k < 1500; k++) begin
        logic we_r;
        if ($urandom_range(0, 15) == 0) e_r[$urandom_range(0, NCH - 1)] ^= 1'b1;
        we_r = ($urandom_range(0, 5) == 0);
        cyc(e_r, we_r, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)));
      end
    end

    // Async reset mid-run, then defaults everywhere.
    for (int k = 0; k < 6; k++) cyc(4'hF, 1'b0, 2'd0, 20'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_wave", 32'(wave_out), 32'd0);
    chk("arst_tick", 32'(edge_tick), 32'd0);
    chk("arst_pend", 32'(pend), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_hold_wave", 32'(wave_out), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(4'hF, 1'b0, 2'd0, 20'd0);
      chk("post_rst_wave", 32'(wave_out), (k >= 4 && k < 8) ? 32'hF : 32'd0);
      chk("post_rst_tick", 32'(edge_tick), (k == 4 || k == 8) ? 32'hF : 32'd0);
    end

    // Out-of-range channel writes on a 5-channel instance.
    cyc5(5'b00000, 1'b1, 3'd5, 8'd9);
    chk("oor5_pend", 32'(p5), 32'd0);
    cyc5(5'b00000, 1'b1, 3'd7, 8'd9);
    chk("oor7_pend", 32'(p5), 32'd0);
    cyc5(5'b00000, 1'b1, 3'd4, 8'd2);
    chk("ch4_pend_set", 32'(p5), 32'b10000);
    cyc5(5'b00000, 1'b0, 3'd0, 8'd0);
    chk("ch4_pend_clr", 32'(p5), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc5(5'b10000, 1'b0, 3'd0, 8'd0);
      chk("ch4_wave", 32'(w5), (k == 2 || k == 3) ? 32'b10000 : 32'd0);
      chk("ch4_tick", 32'(t5), (k == 2 || k == 4) ? 32'b10000 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tone_divider.md
# tone_divider

Multi-channel programmable square-wave generator for the piano audio path, the parametrised successor to the fixed-ratio clock divider. Each of NCH channels divides the system clock by a run-time half-period value, so one block can drive several simultaneous notes. Half-period updates are glitch-free: they take effect only at a half-period boundary, or at once if the channel is idle. Per-channel toggle ticks are provided so downstream logic (envelope, LEDs, score) can stay synchronous to clk.

## Interface
- NCH, 4, number of independent channels (1..16)
- W, 20, half-period counter width in bits
- DEF_HALF, 50000, active half-period of every channel after reset; must fit in W bits
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  single-cycle write strobe for a channel half-period
- cfg_ch  in  CHW  target channel, CHW = max(1, clog2(NCH))
- cfg_half  in  W  new half-period in clk cycles; 0 = silent
- en  in  NCH  per-channel run enable
- wave_out  out  NCH  registered square wave per channel
- edge_tick  out  NCH  one-cycle pulse, same cycle wave_out changes
- pend  out  NCH  a written half-period is waiting for the next boundary

## Operation
- Per channel: registers active half `h`, shadow `s`, counter `cnt` (W bits), `wave`, `tick`, `pend`.
- Reset (async, rst_n=0): wave_out=0, edge_tick=0, pend=0, cnt=0, h=DEF_HALF, s=0.
- States per channel, decoded from registers:
  - IDLE: en=0 or h=0.
  - RUN: en=1 and h≠0.
- IDLE:
  - cnt←0, wave←0, tick←0.
  - Any pending s is committed: h←s, pend←0.
- RUN, cnt≠h−1: cnt←cnt+1, tick←0.
- RUN, cnt==h−1 (boundary):
  - cnt←0, wave←~wave, tick←1.
  - If pend=1: h←s, pend←0.
- Config write (cfg_we=1, cfg_ch<NCH): s←cfg_half, pend←1 on that channel only. cfg_ch≥NCH is ignored.
- Write in the same cycle as a boundary or IDLE commit on that channel: the new value is latched into s with pend=1, and the commit uses the old s. Last write always wins and is never lost.
- Repeated writes before a boundary overwrite s; only the last one is applied.
- Committing h=0 while in RUN: the channel enters IDLE on the next cycle. wave_out is forced to 0 one cycle after the commit edge.
- en falling mid-period: the next edge forces wave←0 and cnt←0 with no tick, even if wave was 1.
- Output period in RUN = 2·h clk cycles at 50 % duty. h=1 gives clk/2.
- Channels are fully independent and share no counters.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- First enabled edge E0 is the first rising edge at which en=1 and h≠0 are sampled, starting from cnt=0.
  - wave_out rises and edge_tick pulses after edge E0+(h−1).
  - Toggles then repeat every h edges.
- pend rises the edge after the cfg_we cycle.
  - It falls after the boundary edge that commits, or after the first edge if the channel is IDLE.
- The new half-period governs the half-period that starts right after the commit boundary. The half-period in progress is never shortened or stretched.
- edge_tick is high for exactly one cycle per wave_out transition, never otherwise. No tick occurs on a forced-low IDLE transition.
- Write-to-effect latency: 1 cycle when IDLE; otherwise up to h cycles (to the boundary).

## Test plan
- Reset/default: NCH=4, W=20, DEF_HALF=4, en=4'b0001 after reset release → wave_out[0] toggles every 4 edges (period 8); edge_tick[0] pulses on each toggle; other channels stay 0.
- Glitch-free update: ch0 running h=4, write cfg_half=2 at cnt=1 → pend[0]=1 until the boundary. The current half-period still lasts 4 cycles, then half-periods of 2 follow and pend[0] drops.
- Idle write and h=1: en[1]=0, write ch1 cfg_half=1 → pend[1] clears after 1 edge. Raise en[1] → wave_out[1] toggles every cycle and edge_tick[1] stays continuously high.
- Silence and disable: commit cfg_half=0 on a running channel → wave_out goes 0, no further ticks. Separately, drop en mid-high-phase → wave_out 0 on the next edge, no tick; re-enable → first rise after h edges.
- Collisions: write ch2 in the same cycle as its boundary, then two back-to-back writes (6, then 3) → the first commit uses the old s; the final h=3 is applied; cfg_ch=5 (≥NCH) changes nothing.
- Async reset mid-run: assert rst_n low between clock edges with all channels running → all outputs and pend are 0 immediately. After release, every channel uses h=DEF_HALF.
